// File: rtl/prga_decrypt.sv
// RC4 pseudo-random generation + decrypt engine: walks S with the i/j swap
// sequence and writes keystream ^ ROM byte into the decrypted RAM.
// Optional printable-ASCII abort is enabled by defining PRGA_ASCII_CHECK_EN.
module prga_decrypt #(
  parameter int MSG_LEN = 32
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic [7:0] s_rddata,
  output logic [7:0] s_addr,
  output logic [7:0] s_wrdata,
  output logic       s_wren,
  output logic [7:0] rom_addr,
  input  logic [7:0] rom_rddata,
  output logic [7:0] dec_addr,
  output logic [7:0] dec_wrdata,
  output logic       dec_wren,
  output logic       done,
  output logic       msg_bad
);

  localparam logic [3:0] IDLE    = 4'd0;
  localparam logic [3:0] READ_I  = 4'd1;
  localparam logic [3:0] LATCH_I = 4'd2;
  localparam logic [3:0] READ_J  = 4'd3;
  localparam logic [3:0] LATCH_J = 4'd4;
  localparam logic [3:0] WRITE_I = 4'd5;
  localparam logic [3:0] WRITE_J = 4'd6;
  localparam logic [3:0] READ_F  = 4'd7;
  localparam logic [3:0] LATCH_F = 4'd8;
  localparam logic [3:0] WRITE_D = 4'd9;
  localparam logic [3:0] DONE    = 4'd10;

  localparam logic [7:0] LAST_K = 8'(MSG_LEN - 1);

  logic [3:0] state_q, state_d;
  logic [7:0] i_q, i_d;
  logic [7:0] j_q, j_d;
  logic [7:0] k_q, k_d;
  logic [7:0] si_q, si_d;
  logic [7:0] sj_q, sj_d;
  logic [7:0] f_q, f_d;
  logic [7:0] enc_q, enc_d;
  logic       done_q, done_d;
  logic       msg_bad_q, msg_bad_d;

  logic [7:0] s_addr_q, s_addr_d;
  logic [7:0] s_wrdata_q, s_wrdata_d;
  logic       s_wren_q, s_wren_d;
  logic [7:0] rom_addr_q, rom_addr_d;
  logic [7:0] dec_addr_q, dec_addr_d;
  logic [7:0] dec_wrdata_q, dec_wrdata_d;
  logic       dec_wren_q, dec_wren_d;

  logic [7:0] dec_byte;
  logic       bad_byte;

  assign dec_byte = f_q ^ enc_q;

`ifdef PRGA_ASCII_CHECK_EN
  logic ascii_ok;
  assign ascii_ok = ((dec_byte >= 8'h61) && (dec_byte <= 8'h7A)) || (dec_byte == 8'h20);
  assign bad_byte = ~ascii_ok;
`else
  assign bad_byte = 1'b0;
`endif

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
    state_d      = state_q;
    i_d          = i_q;
    j_d          = j_q;
    k_d          = k_q;
    si_d         = si_q;
    sj_d         = sj_q;
    f_d          = f_q;
    enc_d        = enc_q;
    done_d       = done_q;
    msg_bad_d    = msg_bad_q;
    s_addr_d     = s_addr_q;
    s_wrdata_d   = s_wrdata_q;
    s_wren_d     = 1'b0;
    rom_addr_d   = rom_addr_q;
    dec_addr_d   = dec_addr_q;
    dec_wrdata_d = dec_wrdata_q;
    dec_wren_d   = 1'b0;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          i_d       = 8'd1;
          j_d       = 8'd0;
          k_d       = 8'd0;
          done_d    = 1'b0;
          msg_bad_d = 1'b0;
          state_d   = READ_I;
        end
      end
      READ_I:  state_d = LATCH_I;
      LATCH_I: begin
        si_d    = s_rddata;
        j_d     = j_q + s_rddata;
        state_d = READ_J;
      end
      READ_J:  state_d = LATCH_J;
      LATCH_J: begin
        sj_d    = s_rddata;
        state_d = WRITE_I;
      end
      WRITE_I: state_d = WRITE_J;
      WRITE_J: state_d = READ_F;
      READ_F:  state_d = LATCH_F;
      LATCH_F: begin
        f_d     = s_rddata;
        enc_d   = rom_rddata;
        state_d = WRITE_D;
      end
      WRITE_D: begin
        msg_bad_d = msg_bad_q | bad_byte;
        if ((k_q == LAST_K) || bad_byte) begin
          done_d  = 1'b1;
          state_d = DONE;
        end else begin
          k_d     = k_q + 8'd1;
          i_d     = i_q + 8'd1;
          state_d = READ_I;
        end
      end
      default: state_d = IDLE;
    endcase

    // Memory-port outputs are registered: decode them from the state being entered.
    case (state_d)
      READ_I: s_addr_d = i_d;
      READ_J: s_addr_d = j_d;
      WRITE_I: begin
        s_addr_d   = i_d;
        s_wrdata_d = sj_d;
        s_wren_d   = 1'b1;
      end
      WRITE_J: begin
        s_addr_d   = j_d;
        s_wrdata_d = si_d;
        s_wren_d   = 1'b1;
      end
      READ_F: begin
        s_addr_d   = si_d + sj_d;
        rom_addr_d = k_d;
      end
      WRITE_D: begin
        dec_addr_d   = k_d;
        dec_wrdata_d = f_d ^ enc_d;
        dec_wren_d   = 1'b1;
      end
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      i_q          <= 8'd0;
      j_q          <= 8'd0;
      k_q          <= 8'd0;
      si_q         <= 8'd0;
      sj_q         <= 8'd0;
      f_q          <= 8'd0;
      enc_q        <= 8'd0;
      done_q       <= 1'b0;
      msg_bad_q    <= 1'b0;
      s_addr_q     <= 8'd0;
      s_wrdata_q   <= 8'd0;
      s_wren_q     <= 1'b0;
      rom_addr_q   <= 8'd0;
      dec_addr_q   <= 8'd0;
      dec_wrdata_q <= 8'd0;
      dec_wren_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      i_q          <= i_d;
      j_q          <= j_d;
      k_q          <= k_d;
      si_q         <= si_d;
      sj_q         <= sj_d;
      f_q          <= f_d;
      enc_q        <= enc_d;
      done_q       <= done_d;
      msg_bad_q    <= msg_bad_d;
      s_addr_q     <= s_addr_d;
      s_wrdata_q   <= s_wrdata_d;
      s_wren_q     <= s_wren_d;
      rom_addr_q   <= rom_addr_d;
      dec_addr_q   <= dec_addr_d;
      dec_wrdata_q <= dec_wrdata_d;
      dec_wren_q   <= dec_wren_d;
    end
  end

  assign s_addr     = s_addr_q;
  assign s_wrdata   = s_wrdata_q;
  assign s_wren     = s_wren_q;
  assign rom_addr   = rom_addr_q;
  assign dec_addr   = dec_addr_q;
  assign dec_wrdata = dec_wrdata_q;
  assign dec_wren   = dec_wren_q;
  assign done       = done_q;
  assign msg_bad    = msg_bad_q;

endmodule

// File: tb/tb_prga_decrypt.sv
// Scoreboard bench for prga_decrypt: a software RC4 PRGA model predicts every
// decrypted-RAM write; instance 0 uses MSG_LEN=32, instance 1 MSG_LEN=256.
module tb_prga_decrypt;

  localparam int LEN0 = 32;
  localparam int LEN1 = 256;

  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] data;
  } wr_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_n;
  logic       start      [2];
  logic [7:0] s_rddata   [2];
  logic [7:0] s_addr     [2];
  logic [7:0] s_wrdata   [2];
  logic       s_wren     [2];
  logic [7:0] rom_addr   [2];
  logic [7:0] rom_rddata [2];
  logic [7:0] dec_addr   [2];
  logic [7:0] dec_wrdata [2];
  logic       dec_wren   [2];
  logic       done       [2];
  logic       msg_bad    [2];

  logic [7:0] s_mem     [2][256];
  logic [7:0] rom_mem   [2][256];
  logic [7:0] dec_mem   [2][256];
  logic [7:0] model_s   [2][256];
  logic [7:0] model_rom [2][256];
  logic       load      [2];

  wr_t exp_q [2][$];
  int  n_pass   = 0;
  int  n_checks = 0;

  prga_decrypt #(.MSG_LEN(LEN0)) u_dut0 (
    .clk(clk), .reset_n(reset_n), .start(start[0]), .s_rddata(s_rddata[0]),
    .s_addr(s_addr[0]), .s_wrdata(s_wrdata[0]), .s_wren(s_wren[0]),
    .rom_addr(rom_addr[0]), .rom_rddata(rom_rddata[0]), .dec_addr(dec_addr[0]),
    .dec_wrdata(dec_wrdata[0]), .dec_wren(dec_wren[0]), .done(done[0]),
    .msg_bad(msg_bad[0])
  );

  prga_decrypt #(.MSG_LEN(LEN1)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .start(start[1]), .s_rddata(s_rddata[1]),
    .s_addr(s_addr[1]), .s_wrdata(s_wrdata[1]), .s_wren(s_wren[1]),
    .rom_addr(rom_addr[1]), .rom_rddata(rom_rddata[1]), .dec_addr(dec_addr[1]),
    .dec_wrdata(dec_wrdata[1]), .dec_wren(dec_wren[1]), .done(done[1]),
    .msg_bad(msg_bad[1])
  );

  // Synchronous memories with one cycle of read latency; a load copies the model image in.
  always @(posedge clk) begin
    for (int n = 0; n < 2; n++) begin
      if (load[n]) begin
        for (int a = 0; a < 256; a++) begin
          s_mem[n][a]   <= model_s[n][a];
          rom_mem[n][a] <= model_rom[n][a];
          dec_mem[n][a] <= 8'h00;
        end
      end else begin
        if (s_wren[n]) s_mem[n][s_addr[n]] <= s_wrdata[n];
        if (dec_wren[n]) dec_mem[n][dec_addr[n]] <= dec_wrdata[n];
        s_rddata[n]   <= s_mem[n][s_addr[n]];
        rom_rddata[n] <= rom_mem[n][rom_addr[n]];
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual %0h expected %0h", name, act, exp);
  endtask

  function automatic bit is_ascii(input logic [7:0] b);
    return ((b >= 8'h61) && (b <= 8'h7A)) || (b == 8'h20);
  endfunction

  // Software RC4 PRGA: pushes expected RAM writes, updates model S, returns bytes written.
  function automatic int model_run(input int n, input int len);
    logic [7:0] i = 8'd0;
    logic [7:0] j = 8'd0;
    logic [7:0] t, idx, o;
    int cnt = 0;
    for (int k = 0; k < len; k++) begin
      i = i + 8'd1;
      j = j + model_s[n][i];
      t = model_s[n][i];
      model_s[n][i] = model_s[n][j];
      model_s[n][j] = t;
      idx = model_s[n][i] + model_s[n][j];
      o = model_s[n][idx] ^ model_rom[n][k];
      exp_q[n].push_back('{addr: 8'(k), data: o});
      cnt++;
`ifdef PRGA_ASCII_CHECK_EN
      if (!is_ascii(o)) break;
`endif
    end
    return cnt;
  endfunction

  // Scoreboard monitor: every RAM write must match the next predicted one.
  always @(negedge clk) begin
    for (int n = 0; n < 2; n++) begin
      if (reset_n && dec_wren[n]) begin
        if (exp_q[n].size() == 0) begin
          check($sformatf("u%0d unexpected dec write @%0h", n, dec_addr[n]), 64'd1, 64'd0);
        end else begin
          wr_t e;
          e = exp_q[n].pop_front();
          check($sformatf("u%0d dec addr", n), 64'(dec_addr[n]), 64'(e.addr));
          check($sformatf("u%0d dec data k=%0d", n, e.addr), 64'(dec_wrdata[n]), 64'(e.data));
`ifndef PRGA_ASCII_CHECK_EN
          check($sformatf("u%0d msg_bad low", n), 64'(msg_bad[n]), 64'd0);
`endif
        end
      end
    end
  end

  // mode 0: identity S, 1: random permutation, 2: keep S from previous run.
  task automatic init_mem(input int n, input int mode, input logic [7:0] rom_fill, input bit rand_rom);
    if (mode != 2) begin
      for (int a = 0; a < 256; a++) model_s[n][a] = 8'(a);
      if (mode == 1) begin
        for (int a = 255; a > 0; a--) begin
          int b;
          logic [7:0] t;
          b = $urandom_range(a, 0);
          t = model_s[n][a];
          model_s[n][a] = model_s[n][b];
          model_s[n][b] = t;
        end
      end
    end
    for (int a = 0; a < 256; a++) model_rom[n][a] = rand_rom ? 8'($urandom) : rom_fill;
    @(negedge clk);
    load[n] = 1'b1;
    @(negedge clk);
    load[n] = 1'b0;
  endtask

  task automatic check_final_s(input int n, input string tag);
    int bad = 0;
    for (int a = 0; a < 256; a++) if (s_mem[n][a] !== model_s[n][a]) bad++;
    check({tag, " S memory mismatches"}, 64'(bad), 64'd0);
  endtask

  task automatic run(input int n, input int len, input int pulse_at, input string tag);
    int nb;
    int cyc = 0;
    nb = model_run(n, len);
    @(negedge clk);
    start[n] = 1'b1;
    @(posedge clk);
    #1;
    start[n] = 1'b0;
    check({tag, " done cleared by start"}, 64'(done[n]), 64'd0);
    while (!done[n] && cyc < 9 * len + 50) begin
      @(posedge clk);
      cyc++;
      #1;
      start[n] = (cyc == pulse_at);
    end
    start[n] = 1'b0;
    check({tag, " done latency"}, 64'(cyc), 64'(9 * nb));
    @(posedge clk);
    #1;
    check({tag, " scoreboard drained"}, 64'(exp_q[n].size()), 64'd0);
    check_final_s(n, tag);
  endtask

  initial begin
    reset_n = 1'b0;
    for (int n = 0; n < 2; n++) begin
      start[n] = 1'b0;
      load[n]  = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int n = 0; n < 2; n++)
      check($sformatf("u%0d reset outputs", n),
            64'({s_addr[n], s_wrdata[n], rom_addr[n], dec_addr[n], dec_wrdata[n],
                 s_wren[n], dec_wren[n], done[n], msg_bad[n]}), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // Identity S, zero ROM: raw keystream 02 05 07 ...
    init_mem(0, 0, 8'h00, 1'b0);
    run(0, LEN0, -1, "t1 identity");
    check("t1 dec[0]", 64'(dec_mem[0][0]), 64'h02);
`ifdef PRGA_ASCII_CHECK_EN
    check("t1 msg_bad", 64'(msg_bad[0]), 64'd1);
    check("t1 no write after abort", 64'(dec_mem[0][1]), 64'h00);
`else
    check("t1 dec[1]", 64'(dec_mem[0][1]), 64'h05);
    check("t1 dec[2]", 64'(dec_mem[0][2]), 64'h07);
`endif

    // Identity S, ROM all 63: printable output a f d ...
    init_mem(0, 0, 8'h63, 1'b0);
    run(0, LEN0, -1, "t2 rom63");
    check("t2 dec[0]", 64'(dec_mem[0][0]), 64'h61);
    check("t2 dec[1]", 64'(dec_mem[0][1]), 64'h66);
    check("t2 dec[2]", 64'(dec_mem[0][2]), 64'h64);

    // start pulsed while the FSM is in READ_J of byte 0 must be ignored.
    init_mem(0, 0, 8'h00, 1'b0);
    run(0, LEN0, 2, "t3 start ignored");
    check("t3 dec[0]", 64'(dec_mem[0][0]), 64'h02);

    // Random S and ROM, back-to-back runs continuing from the swapped S.
    init_mem(0, 1, 8'h00, 1'b1);
    run(0, LEN0, -1, "t4 rand run0");
    for (int r = 1; r < 4; r++) begin
      init_mem(0, 2, 8'h00, 1'b1);
      run(0, LEN0, $urandom_range(20, 1), $sformatf("t4 rand run%0d", r));
    end

    // Reset asserted during WRITE_I of byte 5 (cycle 50 after the start edge).
    init_mem(0, 0, 8'h00, 1'b0);
    void'(model_run(0, LEN0));
    @(negedge clk);
    start[0] = 1'b1;
    @(posedge clk);
    #1;
    start[0] = 1'b0;
    repeat (49) @(posedge clk);
    #1;
    check("t5 in WRITE_I before reset", 64'({s_wren[0], s_addr[0]}), 64'({1'b1, 8'd6}));
    check("t5 bytes 0..4 written", 64'(exp_q[0].size()), 64'(LEN0 - 5));
    #2;
    reset_n = 1'b0;
    #1;
    check("t5 async reset outputs",
          64'({s_addr[0], s_wrdata[0], rom_addr[0], dec_addr[0], dec_wrdata[0],
               s_wren[0], dec_wren[0], done[0], msg_bad[0]}), 64'd0);
    exp_q[0].delete();
    @(negedge clk);
    reset_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("t5 idle after reset", 64'({s_wren[0], dec_wren[0], done[0]}), 64'd0);
    init_mem(0, 0, 8'h00, 1'b0);
    run(0, LEN0, -1, "t5 rerun");

    // Full 256-byte message: i wraps 255 -> 0 on the last byte.
    init_mem(1, 1, 8'h00, 1'b1);
    run(1, LEN1, -1, "t6 len256");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/prga_decrypt.md
# prga_decrypt

RC4 pseudo-random generation and decrypt engine: the reader/consumer of the 256-byte S memory that the S-init/KSA controller writes. After the key schedule has finished, it is pulsed with `start`. It walks the S memory with the RC4 i/j swap sequence and XORs each keystream byte with one encrypted ROM byte. Each result is written into the decrypted-message RAM. It sits beside the top controller in `ksa` and shares `s_memory` with it through a top-level mux.

## Interface
- `MSG_LEN`, default 32: number of message bytes decrypted per run (1..256).
- `clk` in 1: system clock (CLOCK_50).
- `reset_n` in 1: asynchronous, active-low reset.
- `start` in 1: begin a run. Sampled only in IDLE or DONE.
- `s_rddata` in 8: S memory read data. Valid the cycle after its address was presented.
- `s_addr` out 8: S memory address.
- `s_wrdata` out 8: S memory write data.
- `s_wren` out 1: S memory write enable.
- `rom_addr` out 8: encrypted ROM address.
- `rom_rddata` in 8: encrypted ROM data. Same 1-cycle latency as S memory.
- `dec_addr` out 8: decrypted RAM address.
- `dec_wrdata` out 8: decrypted RAM write data.
- `dec_wren` out 1: decrypted RAM write enable.
- `done` out 1: level. High in DONE until the next accepted `start`.
- `msg_bad` out 1: non-printable byte detected (see Configuration).

## Operation
- Internal registers: `i`, `j`, `k` (byte index), `si`, `sj`, `f`, `enc` (all 8 bit). All sums are mod 256 (8-bit wrap, carry dropped).
- Reset: state IDLE; all registers 0; all outputs 0.
- IDLE/DONE + `start`=1:
  - set i=1, j=0, k=0; clear `done` and `msg_bad`;
  - go to READ_I.
- `start` in any other state is ignored.
- States are one cycle each; 9 cycles per byte:
  - READ_I: s_addr=i.
  - LATCH_I: si<=s_rddata; j<=j+s_rddata.
  - READ_J: s_addr=j.
  - LATCH_J: sj<=s_rddata.
  - WRITE_I: s_addr=i, s_wrdata=sj, s_wren=1.
  - WRITE_J: s_addr=j, s_wrdata=si, s_wren=1.
  - READ_F: s_addr=si+sj, rom_addr=k.
  - LATCH_F: f<=s_rddata; enc<=rom_rddata.
  - WRITE_D: dec_addr=k, dec_wrdata=f^enc, dec_wren=1.
    - If k==MSG_LEN-1: go to DONE.
    - Otherwise k<=k+1, i<=i+1, go to READ_I.
- i==j: both swap writes hit the same address with the same value; no special case needed.
- i wraps 255→0 naturally when MSG_LEN is large.
- S is left swapped after a run. A restart continues from the current S; re-initialising S is the caller's job.
- `s_wren`/`dec_wren` are high only in their write states. Address outputs hold their last value elsewhere; their value is don't-care when no read or write is active.
- Reset mid-run returns to IDLE immediately. A partially written S or decrypted RAM is not repaired.

## Timing
- All outputs are registered or decoded from registered state; no combinational path from inputs to outputs.
- `start` is sampled at edge E0. READ_I occupies the cycle after E0.
- `done` rises at edge E0+9·MSG_LEN (288 cycles for MSG_LEN=32).
- Byte k is written on the 9th cycle of its group, i.e. during cycle 9k+9 after E0.
- Throughput: 1 byte / 9 cycles. No back-pressure.

## Configuration
- `PRGA_ASCII_CHECK_EN` defined:
  - Each byte f^enc is checked in WRITE_D; a legal byte is 8'h61–8'h7A or 8'h20.
  - An illegal byte is still written to RAM. In the same edge `msg_bad` is set to 1 and the FSM goes to DONE, ending the run early (used for brute-force key search).
  - `msg_bad` holds until the next accepted `start` or reset.
- Not defined:
  - No check is made; `msg_bad` is tied to 0.
  - Every run writes exactly MSG_LEN bytes.

## Test plan
- Identity S (S[x]=x), ROM all 8'h00, MSG_LEN=32, start → dec[0]=8'h02, dec[1]=8'h05, dec[2]=8'h07. S[2]=8'h03, S[3]=8'h05, S[5]=8'h02 after byte 2. `done` rises 288 cycles after the start edge.
- Identity S, ROM[k]=8'h63 for all k, check macro off → dec[0]=8'h61, dec[1]=8'h66, dec[2]=8'h64. `msg_bad`=0 throughout.
- Same setup with `PRGA_ASCII_CHECK_EN`, ROM[0]=8'h00 → dec[0]=8'h02 written. `msg_bad`=1 and `done`=1 at cycle 9; no `dec_wren` afterward.
- `start` pulsed in READ_J mid-run → ignored. Results and `done` timing identical to the first test.
- `reset_n` low during WRITE_I of byte 5 → all outputs 0 asynchronously; state IDLE; `done`=0. A new start runs to completion.
- MSG_LEN=256 with known S/ROM vectors from the software RC4 model → all 256 RAM bytes match; i wraps correctly.
